// File: rtl/pic_pkg.sv
// Shared types and bit positions for the 8259A-style PIC bus/command front-end.
// Optional poll support is enabled by defining PIC_POLL_EN.
package pic_pkg;

    typedef enum logic [2:0] {
        WAIT_ICW1,
        ICW2,
        ICW3,
        ICW4,
        READY
    } pic_state_e;

    // ICW1 bit positions
    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_ID   = 4;

    // OCW3 bit positions
    localparam int OCW3_RIS  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_P    = 2;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_ESMM = 6;

    // Poll response: {I, 4'b0, level}. IR0 is the highest priority.
    function automatic logic [7:0] poll_word(input logic [7:0] pend);
        logic [7:0] w;
        w = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) w = {1'b1, 4'b0000, 3'(i)};
        end
        return w;
    endfunction

endpackage

// File: rtl/pic_bus_sync.sv
// Falling-edge detection of the CPU write/read strobes, sampled on clk.
// Each strobe pulses for exactly one cycle per falling edge.
module pic_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_n,
    input  logic rd_n,
    output logic wr_stb,
    output logic rd_stb
);

    logic wr_n_q;
    logic rd_n_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_n_q <= 1'b1;
            rd_n_q <= 1'b1;
        end else begin
            wr_n_q <= wr_n;
            rd_n_q <= rd_n;
        end
    end

    assign wr_stb = wr_n_q & ~wr_n;
    assign rd_stb = rd_n_q & ~rd_n;

endmodule

// File: rtl/pic_bus_ctrl.sv
// 8259A-style PIC bus front-end: ICW1..ICW4 init FSM, OCW1..3 decode and read-back/vector bus.
// Define PIC_POLL_EN to add OCW3 poll-command support.
module pic_bus_ctrl
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs_n,
    input  logic               wr_n,
    input  logic               rd_n,
    input  logic               a0,
    input  logic [7:0]         din,
    input  logic [NUM_IRQ-1:0] irr,
    input  logic [NUM_IRQ-1:0] isr,
    input  logic               iv_valid,
    input  logic [VEC_W-1:0]   iv_data,
    output logic [7:0]         dout,
    output logic               dout_oe,
    output logic               init_done,
    output logic [7:0]         icw1_q,
    output logic [7:0]         icw2_q,
    output logic [7:0]         icw3_q,
    output logic [7:0]         icw4_q,
    output logic [NUM_IRQ-1:0] imr,
    output logic [7:0]         ocw2_q,
    output logic               ocw2_stb,
    output logic               rd_sel_isr,
    output logic               smm
);

    pic_state_e state_q;
    logic       wr_stb;
    logic       rd_stb;
    logic       wr_acc;
    logic       icw1_cmd;
    logic [7:0] dout_d;
`ifdef PIC_POLL_EN
    logic       poll_q;
`endif

    pic_bus_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_n   (wr_n),
        .rd_n   (rd_n),
        .wr_stb (wr_stb),
        .rd_stb (rd_stb)
    );

    assign wr_acc   = wr_stb & ~cs_n;
    assign icw1_cmd = wr_acc & ~a0 & din[ICW1_ID];

    // Read data is captured once per rd_n fall from pre-write register values; a vector always wins.
    always_comb begin
        dout_d = dout;
        if (iv_valid) begin
            dout_d = 8'(iv_data);
        end else if (rd_stb && !cs_n) begin
            if (a0) dout_d = 8'(imr);
`ifdef PIC_POLL_EN
            else if (poll_q) dout_d = poll_word(8'(irr & ~imr));
`endif
            else if (rd_sel_isr) dout_d = 8'(isr);
            else dout_d = 8'(irr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_ICW1;
            icw1_q     <= 8'h00;
            icw2_q     <= 8'h00;
            icw3_q     <= 8'h00;
            icw4_q     <= 8'h00;
            imr        <= '0;
            ocw2_q     <= 8'h00;
            ocw2_stb   <= 1'b0;
            rd_sel_isr <= 1'b0;
            smm        <= 1'b0;
            init_done  <= 1'b0;
            dout       <= 8'h00;
            dout_oe    <= 1'b0;
`ifdef PIC_POLL_EN
            poll_q     <= 1'b0;
`endif
        end else begin
            dout     <= dout_d;
            dout_oe  <= (~cs_n & ~rd_n) | iv_valid;
            ocw2_stb <= 1'b0;
`ifdef PIC_POLL_EN
            if (rd_stb && !cs_n && !iv_valid && !a0) poll_q <= 1'b0;
`endif
            if (icw1_cmd) begin
                state_q    <= ICW2;
                icw1_q     <= din;
                imr        <= '0;
                smm        <= 1'b0;
                rd_sel_isr <= 1'b0;
                init_done  <= 1'b0;
                if (!din[ICW1_IC4]) icw4_q <= 8'h00;
`ifdef PIC_POLL_EN
                poll_q     <= 1'b0;
`endif
            end else if (wr_acc && a0) begin
                case (state_q)
                    ICW2: begin
                        icw2_q <= din;
                        if (!icw1_q[ICW1_SNGL]) begin
                            state_q <= ICW3;
                        end else if (icw1_q[ICW1_IC4]) begin
                            state_q <= ICW4;
                        end else begin
                            state_q   <= READY;
                            init_done <= 1'b1;
                        end
                    end
                    ICW3: begin
                        icw3_q <= din;
                        if (icw1_q[ICW1_IC4]) begin
                            state_q <= ICW4;
                        end else begin
                            state_q   <= READY;
                            init_done <= 1'b1;
                        end
                    end
                    ICW4: begin
                        icw4_q    <= din;
                        state_q   <= READY;
                        init_done <= 1'b1;
                    end
                    READY:   imr <= din[NUM_IRQ-1:0];
                    default: ;
                endcase
            end else if (wr_acc && state_q == READY) begin
                // Here a0=0 and din[4]=0, so din[3] alone separates OCW2 from OCW3.
                if (!din[3]) begin
                    ocw2_q   <= din;
                    ocw2_stb <= 1'b1;
                end else begin
                    if (din[OCW3_RR])   rd_sel_isr <= din[OCW3_RIS];
                    if (din[OCW3_ESMM]) smm        <= din[OCW3_SMM];
`ifdef PIC_POLL_EN
                    if (din[OCW3_P])    poll_q     <= 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_pic_bus_ctrl.sv
// Scoreboard bench for pic_bus_ctrl: directed init/OCW/read cases plus random bus traffic
// checked against a behavioural model of the PIC command rules.
module tb_pic_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] irr = 8'h00;
    logic [7:0] isr = 8'h00;
    logic       iv_valid = 1'b0;
    logic [7:0] iv_data = 8'h00;

    logic [7:0] dout;
    logic       dout_oe;
    logic       init_done;
    logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q;
    logic [7:0] imr;
    logic [7:0] ocw2_q;
    logic       ocw2_stb;
    logic       rd_sel_isr;
    logic       smm;

    pic_bus_ctrl #(.NUM_IRQ(8), .VEC_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .wr_n       (wr_n),
        .rd_n       (rd_n),
        .a0         (a0),
        .din        (din),
        .irr        (irr),
        .isr        (isr),
        .iv_valid   (iv_valid),
        .iv_data    (iv_data),
        .dout       (dout),
        .dout_oe    (dout_oe),
        .init_done  (init_done),
        .icw1_q     (icw1_q),
        .icw2_q     (icw2_q),
        .icw3_q     (icw3_q),
        .icw4_q     (icw4_q),
        .imr        (imr),
        .ocw2_q     (ocw2_q),
        .ocw2_stb   (ocw2_stb),
        .rd_sel_isr (rd_sel_isr),
        .smm        (smm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining ICWs are a queue of word numbers still owed by the CPU.
    logic [7:0] m_icw [1:4];
    logic [7:0] m_imr, m_ocw2;
    bit         m_ris, m_smm, m_init, m_poll;
    int         m_need[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] exp_stb_q[$];

    function automatic void model_reset();
        for (int i = 1; i <= 4; i++) m_icw[i] = 8'h00;
        m_imr = 8'h00; m_ocw2 = 8'h00;
        m_ris = 0; m_smm = 0; m_init = 0; m_poll = 0;
        m_need.delete();
    endfunction

    function automatic void model_write(input logic a0v, input logic [7:0] d);
        int n;
        if (!a0v && d[4]) begin
            m_icw[1] = d;
            if (!d[0]) m_icw[4] = 8'h00;
            m_imr = 8'h00; m_smm = 0; m_ris = 0; m_poll = 0; m_init = 0;
            m_need.delete();
            m_need.push_back(2);
            if (!d[1]) m_need.push_back(3);
            if (d[0])  m_need.push_back(4);
        end else if (!m_init) begin
            if (a0v && m_need.size() > 0) begin
                n = m_need.pop_front();
                m_icw[n] = d;
                if (m_need.size() == 0) m_init = 1;
            end
        end else if (a0v) begin
            m_imr = d;
        end else if (d[3] == 1'b0) begin
            m_ocw2 = d;
            exp_stb_q.push_back(d);
        end else begin
            if (d[1]) m_ris = d[0];
            if (d[6]) m_smm = d[5];
`ifdef PIC_POLL_EN
            if (d[2]) m_poll = 1;
`endif
        end
    endfunction

    function automatic logic [7:0] model_read(input logic a0v, input bit iv, input logic [7:0] ivd);
        logic [7:0] pend;
        if (iv) return ivd;
        if (a0v) return m_imr;
        if (m_poll) begin
            m_poll = 0;
            pend = irr & ~m_imr;
            for (int i = 0; i < 8; i++)
                if (pend[i]) return 8'h80 + 8'(i);
            return 8'h00;
        end
        return m_ris ? isr : irr;
    endfunction

    task automatic check_regs();
        check("init_done",  init_done,  m_init);
        check("icw1_q",     icw1_q,     m_icw[1]);
        check("icw2_q",     icw2_q,     m_icw[2]);
        check("icw3_q",     icw3_q,     m_icw[3]);
        check("icw4_q",     icw4_q,     m_icw[4]);
        check("imr",        imr,        m_imr);
        check("ocw2_q_reg", ocw2_q,     m_ocw2);
        check("rd_sel_isr", rd_sel_isr, m_ris);
        check("smm",        smm,        m_smm);
    endtask

    // One bus access: optional write and/or read in the same cycle, optional vector presentation.
    task automatic bus(input bit do_wr, input bit do_rd, input logic a0v, input logic [7:0] d,
                       input bit iv = 0, input logic [7:0] ivd = 8'h00);
        @(negedge clk);
        if (do_rd) exp_rd_q.push_back(model_read(a0v, iv, ivd));
        if (do_wr) model_write(a0v, d);
        cs_n = 1'b0; a0 = a0v; din = d;
        wr_n = ~do_wr; rd_n = ~do_rd;
        iv_valid = iv; iv_data = ivd;
        if (do_rd) begin
            #1 check("oe_latency", dout_oe, 1'b0);
        end
        @(negedge clk);
        wr_n = 1'b1;
        if (do_rd) @(negedge clk);
        rd_n = 1'b1; cs_n = 1'b1; iv_valid = 1'b0;
        @(negedge clk);
        check_regs();
    endtask

    task automatic wr(input logic a0v, input logic [7:0] d);
        bus(1, 0, a0v, d);
    endtask

    task automatic rd(input logic a0v);
        bus(0, 1, a0v, 8'h00);
    endtask

    // Monitor: pops one expected read value per rising dout_oe and one OCW2 per strobe cycle.
    logic prev_oe = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_oe && !prev_oe) begin
                if (exp_rd_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_read: dout=%02h with no read pending", dout);
                end else begin
                    check("read_data", dout, exp_rd_q.pop_front());
                end
            end
            if (ocw2_stb) begin
                if (exp_stb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_ocw2_stb: ocw2_q=%02h, no OCW2 pending", ocw2_q);
                end else begin
                    check("ocw2_stb_q", ocw2_q, exp_stb_q.pop_front());
                end
            end
        end
        prev_oe <= dout_oe;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         op;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_regs();
        check("reset_dout",     dout,     8'h00);
        check("reset_dout_oe",  dout_oe,  1'b0);
        check("reset_ocw2_stb", ocw2_stb, 1'b0);
        rst_n = 1'b1;

        // OCWs before any init are ignored
        wr(1, 8'hFF);
        wr(0, 8'h20);

        // ICW1 single, IC4 -> ICW3 skipped
        wr(0, 8'h13); wr(1, 8'h20); wr(1, 8'h01);

        // Cascade: ICW3 taken; an a0=0 non-ICW1 write mid-sequence is ignored
        wr(0, 8'h11); wr(0, 8'h08); wr(1, 8'h08); wr(1, 8'h04); wr(1, 8'h01);

        // OCW1 and mask read-back
        wr(1, 8'hA5); rd(1);

        // OCW3 read-register select
        irr = 8'h12; isr = 8'h40;
        wr(0, 8'h0B); rd(0);
        wr(0, 8'h0A); rd(0);

        // OCW2 strobe, then re-init mid-operation
        wr(0, 8'h20);
        wr(0, 8'h13); wr(1, 8'h20); wr(1, 8'h03);

        // Write and read in the same cycle return the pre-write mask
        bus(1, 1, 1, 8'h3C);
        rd(1);

        // Vector beats register read, also without chip select routing
        bus(0, 1, 1, 8'h00, 1, 8'h48);

        // Random traffic
        for (int it = 0; it < 80; it++) begin
            irr = 8'($urandom); isr = 8'($urandom);
            op  = $urandom_range(0, 6);
            case (op)
                0: wr(1, 8'($urandom));
                1: begin d = 8'($urandom) & 8'he7; wr(0, d); end
                2: begin d = (8'($urandom) & 8'h67) | 8'h08; wr(0, d); end
                3, 4, 5: bus(0, 1, 1'($urandom), 8'h00, ($urandom_range(0, 3) == 0), 8'($urandom));
                default: begin
                    if ($urandom_range(0, 2) == 0) begin
                        d = (8'($urandom) & 8'he3) | 8'h10;
                        wr(0, d);
                    end else begin
                        bus(1, 1, 1, 8'($urandom));
                    end
                end
            endcase
        end

        // Async reset mid-ICW3 returns everything to reset state
        wr(0, 8'h11); wr(1, 8'h30);
        @(negedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_init_done", init_done, 1'b0);
        check("async_icw1_q",    icw1_q,    8'h00);
        check("async_icw2_q",    icw2_q,    8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wr(1, 8'h55);

        for (int i = 0; i < 20 && (exp_rd_q.size() != 0 || exp_stb_q.size() != 0); i++)
            @(negedge clk);
        check("rd_queue_drained",  8'(exp_rd_q.size()),  8'h00);
        check("stb_queue_drained", 8'(exp_stb_q.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
